// File: rtl/simon_seq_engine.sv
// Simon-style memory game sequencer.
// Plays back a growing prefix of a seeded colour sequence, then checks the
// player's guesses one by one, with optional per-round speed-up and lives.
module simon_seq_engine #(
  parameter int MAX_ROUNDS = 10,
  parameter int COLOR_W    = 2,
  parameter int TIMER_W    = 28,
  parameter int LIVES      = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          seed_valid,
  input  logic [MAX_ROUNDS*COLOR_W-1:0] seed,
  input  logic [TIMER_W-1:0]            step_ticks,
  input  logic                          speedup,
  input  logic                          round_go,
  input  logic [COLOR_W:0]              guess,
  input  logic                          guess_valid,
  output logic [COLOR_W:0]              display,
  output logic [$clog2(MAX_ROUNDS+1)-1:0] round,
  output logic [2:0]                    lives_left,
  output logic                          awaiting,
  output logic                          win,
  output logic                          lose
);

  localparam int RW = $clog2(MAX_ROUNDS+1);
  localparam int NE = 2**RW;

  typedef enum logic [3:0] {
    IDLE, SEED, WAIT_GO, SHOW_ON, SHOW_OFF, GUESS, CHECK, ADVANCE, WIN, LOSE
  } state_t;

  state_t                        state_reg;
  logic [MAX_ROUNDS*COLOR_W-1:0] seq_reg;
  logic [RW-1:0]                 idx_reg;
  logic [RW-1:0]                 gidx_reg;
  logic [TIMER_W-1:0]            timer_reg;
  logic [COLOR_W:0]              guess_reg;

  // Sequence unpacked into a power-of-two array so any RW-bit index is in range.
  logic [COLOR_W-1:0] elem [NE];

  for (genvar gi = 0; gi < NE; gi++) begin : g_elem
    if (gi < MAX_ROUNDS) begin : g_used
      assign elem[gi] = seq_reg[gi*COLOR_W +: COLOR_W];
    end else begin : g_pad
      assign elem[gi] = '0;
    end
  end

  logic [RW-1:0]      round_m1;
  logic [RW-1:0]      idx_inc;
  logic [2:0]         shift_amt;
  logic [TIMER_W-1:0] t_shift;
  logic [TIMER_W-1:0] t_eff;
  logic [COLOR_W:0]   first_code;
  logic [COLOR_W:0]   next_code;
  logic [COLOR_W:0]   exp_code;

  assign round_m1   = round - 1'b1;
  assign idx_inc    = idx_reg + 1'b1;
  // Display time halves every four rounds when speedup is enabled.
  assign shift_amt  = 3'(round_m1 >> 2);
  assign t_shift    = speedup ? (step_ticks >> shift_amt) : step_ticks;
  assign t_eff      = (t_shift == '0) ? TIMER_W'(1) : t_shift;
  assign first_code = {1'b0, elem[0]} + 1'b1;
  assign next_code  = {1'b0, elem[idx_inc]} + 1'b1;
  assign exp_code   = {1'b0, elem[gidx_reg]} + 1'b1;

  // Game FSM with registered outputs; start low aborts everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      seq_reg    <= '0;
      idx_reg    <= '0;
      gidx_reg   <= '0;
      timer_reg  <= '0;
      guess_reg  <= '0;
      display    <= '0;
      round      <= '0;
      lives_left <= '0;
      awaiting   <= 1'b0;
      win        <= 1'b0;
      lose       <= 1'b0;
    end else begin
      awaiting <= 1'b0;
      if (state_reg != IDLE && !start) begin
        state_reg <= IDLE;
        display   <= '0;
        round     <= '0;
        win       <= 1'b0;
        lose      <= 1'b0;
        timer_reg <= '0;
        idx_reg   <= '0;
        gidx_reg  <= '0;
      end else begin
        case (state_reg)
          IDLE: begin
            win     <= 1'b0;
            lose    <= 1'b0;
            round   <= '0;
            display <= '0;
            if (start) state_reg <= SEED;
          end
          SEED: begin
            if (seed_valid) begin
              seq_reg    <= seed;
              round      <= RW'(1);
              lives_left <= 3'(LIVES);
              state_reg  <= WAIT_GO;
            end
          end
          WAIT_GO: begin
            if (round_go) begin
              idx_reg   <= '0;
              display   <= first_code;
              timer_reg <= t_eff;
              state_reg <= SHOW_ON;
            end
          end
          SHOW_ON: begin
            if (timer_reg <= TIMER_W'(1)) begin
              display   <= '0;
              timer_reg <= t_eff;
              state_reg <= SHOW_OFF;
            end else begin
              timer_reg <= timer_reg - 1'b1;
            end
          end
          SHOW_OFF: begin
            if (timer_reg <= TIMER_W'(1)) begin
              if (idx_reg < round_m1) begin
                idx_reg   <= idx_inc;
                display   <= next_code;
                timer_reg <= t_eff;
                state_reg <= SHOW_ON;
              end else begin
                gidx_reg  <= '0;
                timer_reg <= '0;
                awaiting  <= 1'b1;
                state_reg <= GUESS;
              end
            end else begin
              timer_reg <= timer_reg - 1'b1;
            end
          end
          GUESS: begin
            if (guess_valid) begin
              guess_reg <= guess;
              state_reg <= CHECK;
            end else begin
              awaiting <= 1'b1;
            end
          end
          CHECK: begin
            // A zero guess can never equal exp_code, which is always >= 1.
            if (guess_reg == exp_code) begin
              if (gidx_reg == round_m1) begin
                state_reg <= ADVANCE;
              end else begin
                gidx_reg  <= gidx_reg + 1'b1;
                awaiting  <= 1'b1;
                state_reg <= GUESS;
              end
            end else if (lives_left > 3'd1) begin
              lives_left <= lives_left - 1'b1;
              state_reg  <= WAIT_GO;
            end else begin
              lives_left <= '0;
              lose       <= 1'b1;
              state_reg  <= LOSE;
            end
          end
          ADVANCE: begin
            if (round == RW'(MAX_ROUNDS)) begin
              win       <= 1'b1;
              state_reg <= WIN;
            end else begin
              round     <= round + 1'b1;
              state_reg <= WAIT_GO;
            end
          end
          WIN:     win  <= 1'b1;
          LOSE:    lose <= 1'b1;
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_simon_seq_engine.sv
// Directed testbench for simon_seq_engine: one default-width instance with
// two lives, one small instance (2 rounds, 8 colours, single life).
module tb_simon_seq_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Instance A: MAX_ROUNDS=10, COLOR_W=2, LIVES=2
  logic        start, seed_valid, speedup, round_go, guess_valid;
  logic [19:0] seed;
  logic [27:0] step_ticks;
  logic [2:0]  guess;
  logic [2:0]  display;
  logic [3:0]  round;
  logic [2:0]  lives_left;
  logic        awaiting, win, lose;

  // Instance B: MAX_ROUNDS=2, COLOR_W=3, LIVES=1
  logic        b_start, b_seed_valid, b_speedup, b_round_go, b_guess_valid;
  logic [5:0]  b_seed;
  logic [27:0] b_step;
  logic [3:0]  b_guess;
  logic [3:0]  b_display;
  logic [1:0]  b_round;
  logic [2:0]  b_lives;
  logic        b_awaiting, b_win, b_lose;

  simon_seq_engine #(.MAX_ROUNDS(10), .COLOR_W(2), .TIMER_W(28), .LIVES(2)) dut_a (
    .clk(clk), .rst(rst), .start(start), .seed_valid(seed_valid), .seed(seed),
    .step_ticks(step_ticks), .speedup(speedup), .round_go(round_go),
    .guess(guess), .guess_valid(guess_valid), .display(display), .round(round),
    .lives_left(lives_left), .awaiting(awaiting), .win(win), .lose(lose)
  );

  simon_seq_engine #(.MAX_ROUNDS(2), .COLOR_W(3), .TIMER_W(28), .LIVES(1)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .seed_valid(b_seed_valid), .seed(b_seed),
    .step_ticks(b_step), .speedup(b_speedup), .round_go(b_round_go),
    .guess(b_guess), .guess_valid(b_guess_valid), .display(b_display), .round(b_round),
    .lives_left(b_lives), .awaiting(b_awaiting), .win(b_win), .lose(b_lose)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected colour code (1-based) of element i of the A-side seed.
  function automatic int code_a(input int i);
    logic [19:0] s;
    s = seed;
    return int'((s >> (2*i)) & 20'h3) + 1;
  endfunction

  // Expected display time for round r on the A side.
  function automatic int t_of(input int r);
    int t;
    t = speedup ? int'(step_ticks >> ((r-1)/4)) : int'(step_ticks);
    if (t == 0) t = 1;
    return t;
  endfunction

  task automatic pulse_go();
    @(negedge clk); round_go = 1'b1;
    @(negedge clk); round_go = 1'b0;
  endtask

  task automatic submit(input logic [2:0] g);
    @(negedge clk); guess = g; guess_valid = 1'b1;
    @(negedge clk); guess_valid = 1'b0;
  endtask

  // Called right after pulse_go: checks every on/off slot of the playback.
  task automatic watch_playback(input int r);
    int t;
    t = t_of(r);
    for (int e = 0; e < r; e++) begin
      for (int k = 0; k < t; k++) begin
        check($sformatf("disp_on r%0d e%0d", r, e), display, code_a(e));
        @(negedge clk);
      end
      for (int k = 0; k < t; k++) begin
        check($sformatf("disp_off r%0d e%0d", r, e), display, 0);
        @(negedge clk);
      end
    end
    check($sformatf("awaiting r%0d", r), awaiting, 1);
  endtask

  task automatic play_round_ok(input int r);
    pulse_go();
    watch_playback(r);
    for (int e = 0; e < r; e++) submit(3'(code_a(e)));
    repeat (2) @(negedge clk);
    if (r < 10) check($sformatf("round_after r%0d", r), round, r + 1);
    else        check("win_after_r10", win, 1);
    $display("round %0d played (T=%0d): round=%0d win=%0d", r, t_of(r), round, win);
  endtask

  task automatic start_game();
    @(negedge clk); start = 1'b1;
    @(negedge clk); seed_valid = 1'b1;
    @(negedge clk); seed_valid = 1'b0;
    check("seed_round", round, 1);
    check("seed_lives", lives_left, 2);
  endtask

  task automatic stop_game();
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    check("stop_win", win, 0);
    check("stop_lose", lose, 0);
    check("stop_round", round, 0);
    check("stop_display", display, 0);
  endtask

  task automatic b_pulse(input int which);
    @(negedge clk);
    if (which == 0) b_round_go = 1'b1; else b_seed_valid = 1'b1;
    @(negedge clk); b_round_go = 1'b0; b_seed_valid = 1'b0;
  endtask

  task automatic b_submit(input logic [3:0] g);
    @(negedge clk); b_guess = g; b_guess_valid = 1'b1;
    @(negedge clk); b_guess_valid = 1'b0;
  endtask

  // B playback with step 2: each code lit 2 clocks then dark 2 clocks.
  task automatic b_watch(input int n);
    int codes [2];
    codes = '{4, 6};
    b_pulse(0);
    for (int e = 0; e < n; e++) begin
      repeat (2) begin check($sformatf("b_on e%0d", e), b_display, codes[e]); @(negedge clk); end
      repeat (2) begin check($sformatf("b_off e%0d", e), b_display, 0); @(negedge clk); end
    end
    check("b_awaiting", b_awaiting, 1);
  endtask

  initial begin
    rst = 1'b1;
    start = 0; seed_valid = 0; speedup = 0; round_go = 0; guess_valid = 0;
    seed = 20'h0001B; step_ticks = 28'd3; guess = '0;
    b_start = 0; b_seed_valid = 0; b_speedup = 0; b_round_go = 0; b_guess_valid = 0;
    b_seed = 6'b101_011; b_step = 28'd2; b_guess = '0;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_display", display, 0);
    check("rst_round", round, 0);
    check("rst_lives", lives_left, 0);
    check("rst_awaiting", awaiting, 0);
    check("rst_win", win, 0);
    check("rst_lose", lose, 0);
    rst = 1'b1;

    // Full correct game, T=3, plus ignored pulses in SEED and WAIT_GO.
    @(negedge clk); start = 1'b1;
    pulse_go();
    check("go_in_seed_round", round, 0);
    check("go_in_seed_display", display, 0);
    @(negedge clk); seed_valid = 1'b1;
    @(negedge clk); seed_valid = 1'b0;
    check("seed_round", round, 1);
    check("seed_lives", lives_left, 2);
    submit(3'd4);
    check("guess_in_waitgo_awaiting", awaiting, 0);
    check("guess_in_waitgo_lives", lives_left, 2);
    for (int r = 1; r <= 10; r++) play_round_ok(r);
    check("win_display", display, 0);
    check("win_awaiting", awaiting, 0);
    stop_game();

    // Lives: wrong second guess in round 3, then a zero guess loses.
    start_game();
    play_round_ok(1);
    play_round_ok(2);
    pulse_go();
    watch_playback(3);
    submit(3'd4);
    submit(3'd1);
    repeat (2) @(negedge clk);
    check("miss1_lives", lives_left, 1);
    check("miss1_round", round, 3);
    check("miss1_awaiting", awaiting, 0);
    check("miss1_lose", lose, 0);
    pulse_go();
    watch_playback(3);
    submit(3'd0);
    repeat (2) @(negedge clk);
    check("miss2_lose", lose, 1);
    check("miss2_lives", lives_left, 0);
    check("miss2_win", win, 0);
    $display("lives scenario: lose=%0d lives_left=%0d", lose, lives_left);
    stop_game();

    // Speedup: step 8 gives T=2 in round 9; step 1 floors at T=1 in round 10.
    speedup = 1'b1; step_ticks = 28'd8;
    start_game();
    for (int r = 1; r <= 9; r++) play_round_ok(r);
    step_ticks = 28'd1;
    play_round_ok(10);
    stop_game();
    speedup = 1'b0; step_ticks = 28'd3;

    // Abort: start dropped during SHOW_ON together with guess_valid.
    start_game();
    pulse_go();
    check("abort_pre_display", display, 4);
    @(negedge clk); start = 1'b0; guess_valid = 1'b1;
    @(negedge clk); guess_valid = 1'b0;
    check("abort_display", display, 0);
    check("abort_round", round, 0);
    check("abort_win", win, 0);
    check("abort_lose", lose, 0);
    check("abort_awaiting", awaiting, 0);
    $display("abort scenario: display=%0d round=%0d", display, round);

    // Asynchronous reset mid-SHOW_OFF, then guess_valid while not awaiting.
    start_game();
    pulse_go();
    repeat (3) @(negedge clk);
    check("pre_rst_off", display, 0);
    check("pre_rst_round", round, 1);
    #2 rst = 1'b0;
    #1;
    check("arst_display", display, 0);
    check("arst_round", round, 0);
    check("arst_lives", lives_left, 0);
    check("arst_awaiting", awaiting, 0);
    check("arst_win", win, 0);
    check("arst_lose", lose, 0);
    @(negedge clk); rst = 1'b1;
    submit(3'd4);
    check("gv_idle_round", round, 0);
    check("gv_idle_awaiting", awaiting, 0);
    @(negedge clk); seed_valid = 1'b1;
    @(negedge clk); seed_valid = 1'b0;
    check("post_rst_seed_round", round, 1);
    $display("async reset scenario: round=%0d lives=%0d", round, lives_left);
    stop_game();

    // Instance B: 2 rounds, 8 colours, seed 101_011 -> codes 4 then 6.
    @(negedge clk); b_start = 1'b1;
    b_pulse(1);
    check("b_seed_round", b_round, 1);
    check("b_seed_lives", b_lives, 1);
    b_watch(1);
    b_submit(4'd4);
    repeat (2) @(negedge clk);
    check("b_round2", b_round, 2);
    b_watch(2);
    b_submit(4'd4);
    b_submit(4'd6);
    repeat (2) @(negedge clk);
    check("b_win", b_win, 1);
    check("b_lose_at_win", b_lose, 0);
    $display("B game: win=%0d round=%0d", b_win, b_round);
    @(negedge clk); b_start = 1'b0;
    @(negedge clk);
    check("b_win_cleared", b_win, 0);
    @(negedge clk); b_start = 1'b1;
    b_pulse(1);
    b_watch(1);
    b_submit(4'd5);
    repeat (2) @(negedge clk);
    check("b_lose", b_lose, 1);
    check("b_lose_lives", b_lives, 0);
    $display("B game: lose=%0d lives=%0d", b_lose, b_lives);
    @(negedge clk); b_start = 1'b0;
    @(negedge clk);
    check("b_lose_cleared", b_lose, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
